regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, register data width; ADDR_W, 3, register index width (2**ADDR_W registers).
REQ-002 Ports SHALL be, in order:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_start  in  1  request to re-zero registers 1..2**ADDR_W-1.
- stall  in  1  pipeline stall; blocks all acceptance.
- alu_valid  in  1  ALU writeback request.
- alu_reg  in  ADDR_W  ALU destination index.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_reg  in  ADDR_W  load destination index.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- write_enable  out  1  registerFile write strobe.
- write_reg  out  ADDR_W  registerFile write index.
- write_data  out  DATA_W  registerFile write data.
- last_grant  out  1  0 = ALU, 1 = MEM won the last accepted transfer.
- clear_busy  out  1  high while in CLEAR.
- clear_done  out  1  one-cycle pulse on CLEAR exit.

Function
REQ-003 The FSM SHALL have two states, CLEAR and RUN.
REQ-004 CLEAR SHALL drive one registered write per cycle, index counter 1 up to 2**ADDR_W-1, data 0; write_enable high each of those cycles.
REQ-005 After the write to index 2**ADDR_W-1, the FSM SHALL enter RUN and pulse clear_done for exactly one cycle.
REQ-006 In RUN, clear_start high SHALL enter CLEAR next cycle with counter reset to 1; it SHALL be ignored while in CLEAR.
REQ-007 alu_ready and mem_ready SHALL be combinational, SHALL be 0 in CLEAR or when stall=1, and at most one SHALL be 1 in any cycle.
REQ-008 In RUN, not stalled, with only one valid, that requester SHALL see ready=1.
REQ-009 With both valid, the requester not equal to last_grant SHALL see ready=1 (round-robin).
REQ-010 A transfer (valid and ready) SHALL update last_grant at the same edge.
REQ-011 Latency SHALL be one cycle: the accepted reg/data appear on write_reg/write_data with write_enable=1 on the following cycle, for exactly one cycle.
REQ-012 A transfer to index 0 SHALL be accepted and update last_grant, but write_enable SHALL stay 0 and write_reg/write_data SHALL hold.
REQ-013 With no transfer and not in CLEAR, write_enable SHALL be 0 and write_reg/write_data SHALL hold.
REQ-014 Both requesters targeting the same index SHALL be serialised in round-robin order, so the later grant is the final value.
REQ-015 clear_start coincident with a transfer SHALL complete that transfer's write before the first CLEAR write.

Reset
REQ-016 reset_n low SHALL immediately force: state CLEAR, counter 1, write_enable 0, write_reg 0, write_data 0, last_grant 1 (ALU wins first tie), clear_done 0.
REQ-017 On reset_n deassertion, the block SHALL perform a full CLEAR sequence before accepting any request.
REQ-018 Reset asserted mid-CLEAR or mid-transfer SHALL abandon it; no partial write SHALL be issued after release other than the restarted CLEAR.

Structure
REQ-019 A shared package SHALL hold the state encoding (CLEAR, RUN) and the grant encodings (GRANT_ALU=0, GRANT_MEM=1).
REQ-020 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs: two valids, last_grant, enable; outputs: two readies).

Verification
REQ-021 Reset release with ADDR_W=3 -> writes to indices 1..7 with data 0 on 7 consecutive cycles; clear_done pulses once; no ready asserted before it.
REQ-022 RUN, both valid every cycle, alu_reg=2/alu_data=8'h05, mem_reg=3/mem_data=8'h02 -> grants alternate ALU, MEM, ALU...; writes appear one cycle after each grant.
REQ-023 mem_valid only, mem_reg=0, mem_data=8'hFF -> mem_ready=1, last_grant=1, write_enable stays 0.
REQ-024 stall=1 with both valid -> both readies 0 and write_enable 0 until stall drops; next grant follows last_grant.
REQ-025 clear_start in RUN with ALU transfer to index 4, data 8'h09 -> index 4 written with 8'h09, then indices 1..7 zeroed, then clear_done.
REQ-026 reset_n pulsed low during CLEAR at index 4 -> outputs reset at once; after release CLEAR restarts at index 1.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_write_arbiter_pkg                                          |
// | Shared state and grant encodings for the regfile write arbiter.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package regfile_write_arbiter_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2                                                        |
// | Two-way round-robin grant: on a tie the side that lost last wins.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic alu_valid,
  input  logic mem_valid,
  input  logic last_grant,
  input  logic enable,
  output logic alu_ready,
  output logic mem_ready
);

  logic w_tie;

  assign w_tie     = alu_valid & mem_valid;
  assign alu_ready = enable & alu_valid & (~w_tie | (last_grant == GRANT_MEM));
  assign mem_ready = enable & mem_valid & (~w_tie | (last_grant == GRANT_ALU));

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_write_arbiter                                              |
// | Arbitrates ALU/load writebacks onto one regfile port; CLEAR mode   |
// | zeroes registers 1..N-1 one per cycle.                             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_start,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              last_grant,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_LAST_IDX  = {ADDR_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clear_idx;
  logic [ADDR_W-1:0]   w_clear_idx_nxt;
  logic                r_write_enable;
  logic                w_write_enable_nxt;
  logic [ADDR_W-1:0]   r_write_reg;
  logic [ADDR_W-1:0]   w_write_reg_nxt;
  logic [DATA_W-1:0]   r_write_data;
  logic [DATA_W-1:0]   w_write_data_nxt;
  logic                r_last_grant;
  logic                w_last_grant_nxt;
  logic                r_clear_done;
  logic                w_clear_done_nxt;

  logic                w_arb_enable;
  logic                w_alu_xfer;
  logic                w_mem_xfer;
  logic [ADDR_W-1:0]   w_sel_reg;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_arb_enable = (r_state == RUN) & ~stall;

  rr_arbiter2 u_rr_arbiter2 (
    .alu_valid  (alu_valid),
    .mem_valid  (mem_valid),
    .last_grant (r_last_grant),
    .enable     (w_arb_enable),
    .alu_ready  (alu_ready),
    .mem_ready  (mem_ready)
  );

  assign w_alu_xfer = alu_valid & alu_ready;
  assign w_mem_xfer = mem_valid & mem_ready;
  assign w_sel_reg  = w_mem_xfer ? mem_reg  : alu_reg;
  assign w_sel_data = w_mem_xfer ? mem_data : alu_data;

  always_comb begin
    w_state_nxt        = r_state;
    w_clear_idx_nxt    = r_clear_idx;
    w_write_enable_nxt = 1'b0;
    w_write_reg_nxt    = r_write_reg;
    w_write_data_nxt   = r_write_data;
    w_last_grant_nxt   = r_last_grant;
    w_clear_done_nxt   = 1'b0;

    case (r_state)
      CLEAR: begin
        w_write_enable_nxt = 1'b1;
        w_write_reg_nxt    = r_clear_idx;
        w_write_data_nxt   = '0;
        if (r_clear_idx == c_LAST_IDX) begin
          w_state_nxt      = RUN;
          w_clear_done_nxt = 1'b1;
        end else begin
          w_clear_idx_nxt  = r_clear_idx + c_FIRST_IDX;
        end
      end
      RUN: begin
        if (w_alu_xfer | w_mem_xfer) begin
          w_last_grant_nxt = w_mem_xfer ? GRANT_MEM : GRANT_ALU;
          // Register 0 is hardwired: the grant still counts, but no write issues.
          if (w_sel_reg != '0) begin
            w_write_enable_nxt = 1'b1;
            w_write_reg_nxt    = w_sel_reg;
            w_write_data_nxt   = w_sel_data;
          end
        end
        if (clear_start) begin
          w_state_nxt     = CLEAR;
          w_clear_idx_nxt = c_FIRST_IDX;
        end
      end
      default: begin
        w_state_nxt     = CLEAR;
        w_clear_idx_nxt = c_FIRST_IDX;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= CLEAR;
      r_clear_idx    <= c_FIRST_IDX;
      r_write_enable <= 1'b0;
      r_write_reg    <= '0;
      r_write_data   <= '0;
      r_last_grant   <= GRANT_MEM;
      r_clear_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_clear_idx    <= w_clear_idx_nxt;
      r_write_enable <= w_write_enable_nxt;
      r_write_reg    <= w_write_reg_nxt;
      r_write_data   <= w_write_data_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_clear_done   <= w_clear_done_nxt;
    end
  end

  assign write_enable = r_write_enable;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign last_grant   = r_last_grant;
  assign clear_busy   = (r_state == CLEAR);
  assign clear_done   = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_write_arbiter                                           |
// | Directed scenarios plus random traffic against a reference model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_regfile_write_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       clear_start = 1'b0;
  logic       stall = 1'b0;
  logic       alu_valid = 1'b0;
  logic [2:0] alu_reg = '0;
  logic [7:0] alu_data = '0;
  logic       alu_ready;
  logic       mem_valid = 1'b0;
  logic [2:0] mem_reg = '0;
  logic [7:0] mem_data = '0;
  logic       mem_ready;
  logic       write_enable;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic       last_grant;
  logic       clear_busy;
  logic       clear_done;

  int checks = 0;
  int errors = 0;

  // Reference model: the observable behaviour expected after each edge.
  logic       m_clearing;
  int         m_clear_next;
  logic       m_last;
  logic       m_we;
  logic [2:0] m_reg;
  logic [7:0] m_data;
  logic       m_done;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .clear_start  (clear_start),
    .stall        (stall),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .last_grant   (last_grant),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done)
  );

  always #5 clock = ~clock;

  function automatic void model_reset();
    m_clearing   = 1'b1;
    m_clear_next = 1;
    m_last       = 1'b1;
    m_we         = 1'b0;
    m_reg        = '0;
    m_data       = '0;
    m_done       = 1'b0;
  endfunction

  function automatic void model_ready(output logic ar, output logic mr);
    ar = 1'b0;
    mr = 1'b0;
    if (!m_clearing && !stall) begin
      if (alu_valid && mem_valid) begin
        ar = m_last;
        mr = !m_last;
      end else begin
        ar = alu_valid;
        mr = mem_valid;
      end
    end
  endfunction

  function automatic void model_edge();
    logic ar, mr;
    logic [2:0] r;
    logic [7:0] d;
    model_ready(ar, mr);
    m_done = 1'b0;
    if (m_clearing) begin
      m_we   = 1'b1;
      m_reg  = 3'(m_clear_next);
      m_data = '0;
      if (m_clear_next == 7) begin
        m_clearing = 1'b0;
        m_done     = 1'b1;
      end else begin
        m_clear_next++;
      end
    end else begin
      m_we = 1'b0;
      if (ar || mr) begin
        m_last = mr;
        r = mr ? mem_reg  : alu_reg;
        d = mr ? mem_data : alu_data;
        if (r != 0) begin
          m_we   = 1'b1;
          m_reg  = r;
          m_data = d;
        end
      end
      if (clear_start) begin
        m_clearing   = 1'b1;
        m_clear_next = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    alu_valid = 1'b1; alu_reg = 3'd5; alu_data = 8'h11;
    mem_valid = 1'b1; mem_reg = 3'd6; mem_data = 8'h22;
    #1 reset_n = 1'b0;
    model_reset();
    #2;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", write_enable); end
    checks++; if (write_reg !== 3'd0) begin errors++; $display("FAIL reset_reg: got %0d want 0", write_reg); end
    checks++; if (write_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", write_data); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last: got %b want 1", last_grant); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", clear_done); end
    checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", clear_busy); end
    checks++; if ({alu_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {alu_ready, mem_ready}); end
  endtask

  task automatic test_clear_sequence();
    int pulses = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if ({alu_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL clr_ready[%0d]: got %b want 00", i, {alu_ready, mem_ready}); end
      tick();
      checks++; if (write_enable !== 1'b1 || write_reg !== 3'(i + 1) || write_data !== 8'h00)
        begin errors++; $display("FAIL clr_write[%0d]: got we=%b reg=%0d data=%h want we=1 reg=%0d data=00", i, write_enable, write_reg, write_data, i + 1); end
      if (clear_done === 1'b1) pulses++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_exit: got %b want 0", clear_busy); end
    tick();
    if (clear_done === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL clr_done_pulses: got %0d want 1", pulses); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL clr_idle_we: got %b want 0", write_enable); end
  endtask

  task automatic test_alternate();
    logic exp_alu;
    alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'h05;
    mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 8'h02;
    for (int i = 0; i < 6; i++) begin
      exp_alu = (i % 2 == 0);
      #1;
      checks++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu)
        begin errors++; $display("FAIL alt_ready[%0d]: got %b%b want %b%b", i, alu_ready, mem_ready, exp_alu, !exp_alu); end
      tick();
      checks++; if (write_enable !== 1'b1 || write_reg !== (exp_alu ? 3'd2 : 3'd3) || write_data !== (exp_alu ? 8'h05 : 8'h02) || last_grant !== !exp_alu)
        begin errors++; $display("FAIL alt_write[%0d]: got we=%b reg=%0d data=%h last=%b", i, write_enable, write_reg, write_data, last_grant); end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic test_reg0();
    mem_valid = 1'b1; mem_reg = 3'd0; mem_data = 8'hFF;
    #1;
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL r0_ready: got %b%b want 01", alu_ready, mem_ready); end
    tick();
    mem_valid = 1'b0;
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL r0_we: got %b want 0", write_enable); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL r0_last: got %b want 1", last_grant); end
    checks++; if (write_reg !== 3'd3 || write_data !== 8'h02) begin errors++; $display("FAIL r0_hold: got reg=%0d data=%h want 3/02", write_reg, write_data); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    alu_valid = 1'b1; alu_reg = 3'd2; alu_data = 8'h05;
    mem_valid = 1'b1; mem_reg = 3'd3; mem_data = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({alu_ready, mem_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {alu_ready, mem_ready}); end
      tick();
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL stall_we[%0d]: got %b want 0", i, write_enable); end
    end
    stall = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL stall_resume: got %b%b want 10", alu_ready, mem_ready); end
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 3'd2 || write_data !== 8'h05 || last_grant !== 1'b0)
      begin errors++; $display("FAIL stall_write: got we=%b reg=%0d data=%h last=%b", write_enable, write_reg, write_data, last_grant); end
  endtask

  task automatic test_clear_with_transfer();
    alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 8'h09;
    clear_start = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL cwt_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0; clear_start = 1'b0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 3'd4 || write_data !== 8'h09 || clear_busy !== 1'b1)
      begin errors++; $display("FAIL cwt_first: got we=%b reg=%0d data=%h busy=%b want 1/4/09/1", write_enable, write_reg, write_data, clear_busy); end
    for (int i = 0; i < 7; i++) begin
      clear_start = (i >= 1 && i <= 3);
      tick();
      checks++; if (write_enable !== 1'b1 || write_reg !== 3'(i + 1) || write_data !== 8'h00 || clear_done !== (i == 6))
        begin errors++; $display("FAIL cwt_clr[%0d]: got we=%b reg=%0d data=%h done=%b", i, write_enable, write_reg, write_data, clear_done); end
    end
    clear_start = 1'b0;
    tick();
    checks++; if (clear_busy !== 1'b0 || write_enable !== 1'b0) begin errors++; $display("FAIL cwt_exit: got busy=%b we=%b want 0/0", clear_busy, write_enable); end
  endtask

  task automatic test_reset_mid_clear();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (write_reg !== 3'd4 || clear_busy !== 1'b1) begin errors++; $display("FAIL rmc_pre: got reg=%0d busy=%b want 4/1", write_reg, clear_busy); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (write_enable !== 1'b0 || write_reg !== 3'd0 || write_data !== 8'h00 || last_grant !== 1'b1 || clear_done !== 1'b0)
      begin errors++; $display("FAIL rmc_reset: got we=%b reg=%0d data=%h last=%b done=%b", write_enable, write_reg, write_data, last_grant, clear_done); end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (write_enable !== 1'b1 || write_reg !== 3'(i + 1) || write_data !== 8'h00)
        begin errors++; $display("FAIL rmc_clr[%0d]: got we=%b reg=%0d data=%h want 1/%0d/00", i, write_enable, write_reg, write_data, i + 1); end
    end
    tick();
  endtask

  task automatic test_random();
    logic ear, emr;
    for (int i = 0; i < 400; i++) begin
      alu_valid   = ($urandom_range(0, 9) < 7);
      mem_valid   = ($urandom_range(0, 9) < 7);
      alu_reg     = 3'($urandom_range(0, 7));
      mem_reg     = 3'($urandom_range(0, 7));
      alu_data    = 8'($urandom);
      mem_data    = 8'($urandom);
      stall       = ($urandom_range(0, 9) < 2);
      clear_start = ($urandom_range(0, 99) < 4);
      #1;
      model_ready(ear, emr);
      checks++; if (alu_ready !== ear || mem_ready !== emr)
        begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, alu_ready, mem_ready, ear, emr); end
      tick();
      checks++; if (write_enable !== m_we || write_reg !== m_reg || write_data !== m_data)
        begin errors++; $display("FAIL rnd_write[%0d]: got %b/%0d/%h want %b/%0d/%h", i, write_enable, write_reg, write_data, m_we, m_reg, m_data); end
      checks++; if (last_grant !== m_last || clear_done !== m_done || clear_busy !== m_clearing)
        begin errors++; $display("FAIL rnd_status[%0d]: got last=%b done=%b busy=%b want %b/%b/%b", i, last_grant, clear_done, clear_busy, m_last, m_done, m_clearing); end
    end
    stall = 1'b0; clear_start = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clear_sequence();
    test_alternate();
    test_reg0();
    test_stall();
    test_clear_with_transfer();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
